// File: rtl/phys_regfile.sv
// Multi-ported physical register file feeding the issue stage. Read port k serves
// FU slot k (ALU, MULT, LD, ST, BR). Complete-stage writes bypass to every read port
// in the same cycle, so a value completing in cycle t is visible to an instruction
// issuing in cycle t. Physical register 0 is hardwired to zero.
module phys_regfile #(
    parameter int unsigned NUM_RD    = 5,
    parameter int unsigned NUM_WR    = 2,
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned DATA_W    = 32,
    localparam int unsigned IDX_W    = $clog2(PHYS_REGS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_RD*IDX_W-1:0]    rd_idx_1,
    input  logic [NUM_RD*IDX_W-1:0]    rd_idx_2,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_1,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_2,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*IDX_W-1:0]    wr_idx,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [IDX_W-1:0]           dbg_idx,
    output logic [DATA_W-1:0]          dbg_data,
    output logic                       wr_conflict
);

    logic [DATA_W-1:0] mem_q [PHYS_REGS];
    logic              wr_conflict_q;
    logic              wr_conflict_d;

    logic [IDX_W-1:0]  wr_idx_a  [NUM_WR];
    logic [DATA_W-1:0] wr_data_a [NUM_WR];
    logic              wr_live   [NUM_WR];

    // Unpack write ports; a write is live only if enabled, nonzero and in range.
    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_unpack
        assign wr_idx_a[w]  = wr_idx[w*IDX_W +: IDX_W];
        assign wr_data_a[w] = wr_data[w*DATA_W +: DATA_W];
        assign wr_live[w]   = wr_en[w] && (wr_idx_a[w] != '0)
                              && (32'(wr_idx_a[w]) < PHYS_REGS);
    end

    // Read ports: storage value overridden by any matching live write, highest port last.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [IDX_W-1:0]  idx1, idx2;
        logic [DATA_W-1:0] val1, val2;

        assign idx1 = rd_idx_1[k*IDX_W +: IDX_W];
        assign idx2 = rd_idx_2[k*IDX_W +: IDX_W];

        // rs1 read with bypass
        always_comb begin
            val1 = '0;
            if (idx1 != '0 && 32'(idx1) < PHYS_REGS) begin
                val1 = mem_q[idx1];
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_live[w] && wr_idx_a[w] == idx1) val1 = wr_data_a[w];
                end
            end
        end

        // rs2 read with bypass
        always_comb begin
            val2 = '0;
            if (idx2 != '0 && 32'(idx2) < PHYS_REGS) begin
                val2 = mem_q[idx2];
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_live[w] && wr_idx_a[w] == idx2) val2 = wr_data_a[w];
                end
            end
        end

        assign rd_data_1[k*DATA_W +: DATA_W] = val1;
        assign rd_data_2[k*DATA_W +: DATA_W] = val2;
    end

    // Debug read sees storage only, never the in-flight writes.
    always_comb begin
        dbg_data = '0;
        if (dbg_idx != '0 && 32'(dbg_idx) < PHYS_REGS) dbg_data = mem_q[dbg_idx];
    end

    // Flag any pair of live writes targeting the same register.
    always_comb begin
        wr_conflict_d = 1'b0;
        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                if (wr_live[a] && wr_live[b] && wr_idx_a[a] == wr_idx_a[b]) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    // Storage update; later write ports override earlier ones on the same index.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PHYS_REGS; i++) mem_q[i] <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_live[w]) mem_q[wr_idx_a[w]] <= wr_data_a[w];
            end
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_phys_regfile.sv
// Directed and randomized checks for phys_regfile: reset, bypass, zero register,
// multi-write conflicts, broadcast reads, reset mid-write and a scoreboarded stream.
module tb_phys_regfile;

    localparam int NUM_RD    = 5;
    localparam int NUM_WR    = 2;
    localparam int PHYS_REGS = 64;
    localparam int DATA_W    = 32;
    localparam int IDX_W     = 6;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_RD*IDX_W-1:0]   rd_idx_1;
    logic [NUM_RD*IDX_W-1:0]   rd_idx_2;
    logic [NUM_RD*DATA_W-1:0]  rd_data_1;
    logic [NUM_RD*DATA_W-1:0]  rd_data_2;
    logic [NUM_WR-1:0]         wr_en;
    logic [NUM_WR*IDX_W-1:0]   wr_idx;
    logic [NUM_WR*DATA_W-1:0]  wr_data;
    logic [IDX_W-1:0]          dbg_idx;
    logic [DATA_W-1:0]         dbg_data;
    logic                      wr_conflict;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DATA_W-1:0] model [PHYS_REGS];

    phys_regfile #(
        .NUM_RD    (NUM_RD),
        .NUM_WR    (NUM_WR),
        .PHYS_REGS (PHYS_REGS),
        .DATA_W    (DATA_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rd_idx_1    (rd_idx_1),
        .rd_idx_2    (rd_idx_2),
        .rd_data_1   (rd_data_1),
        .rd_data_2   (rd_data_2),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .dbg_idx     (dbg_idx),
        .dbg_data    (dbg_data),
        .wr_conflict (wr_conflict)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] rd1(input int k);
        return rd_data_1[k*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] rd2(input int k);
        return rd_data_2[k*DATA_W +: DATA_W];
    endfunction

    task automatic clear_writes();
        wr_en   = '0;
        wr_idx  = '0;
        wr_data = '0;
    endtask

    task automatic set_wr(input int w, input logic en, input int idx, input logic [31:0] d);
        wr_en[w]                  = en;
        wr_idx[w*IDX_W +: IDX_W]  = IDX_W'(idx);
        wr_data[w*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_rd_all(input int idx);
        for (int k = 0; k < NUM_RD; k++) begin
            rd_idx_1[k*IDX_W +: IDX_W] = IDX_W'(idx);
            rd_idx_2[k*IDX_W +: IDX_W] = IDX_W'(idx);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_writes();
        set_rd_all(0);
        dbg_idx = '0;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < PHYS_REGS; i++) begin
            set_rd_all(i);
            dbg_idx = IDX_W'(i);
            #1;
            for (int k = 0; k < NUM_RD; k++) begin
                total_cnt++;
                if (rd1(k) !== 32'h0 || rd2(k) !== 32'h0)
                    $display("FAIL reset_read idx=%0d port=%0d got %h/%h want 0", i, k, rd1(k), rd2(k));
                else pass_cnt++;
            end
            total_cnt++;
            if (dbg_data !== 32'h0) $display("FAIL reset_dbg idx=%0d got %h want 0", i, dbg_data);
            else pass_cnt++;
        end
        total_cnt++;
        if (wr_conflict !== 1'b0) $display("FAIL reset_conflict got %b want 0", wr_conflict);
        else pass_cnt++;
        step();
    endtask

    task automatic test_bypass();
        clear_writes();
        set_rd_all(0);
        set_wr(0, 1'b1, 5, 32'hDEAD_BEEF);
        rd_idx_1[2*IDX_W +: IDX_W] = 6'd5;
        dbg_idx = 6'd5;
        #1;
        total_cnt++;
        if (rd1(2) !== 32'hDEAD_BEEF) $display("FAIL bypass_same got %h want deadbeef", rd1(2));
        else pass_cnt++;
        total_cnt++;
        if (dbg_data !== 32'h0) $display("FAIL dbg_no_bypass got %h want 0", dbg_data);
        else pass_cnt++;
        step();
        clear_writes();
        #1;
        total_cnt++;
        if (rd1(2) !== 32'hDEAD_BEEF) $display("FAIL bypass_stored got %h want deadbeef", rd1(2));
        else pass_cnt++;
        total_cnt++;
        if (dbg_data !== 32'hDEAD_BEEF) $display("FAIL dbg_stored got %h want deadbeef", dbg_data);
        else pass_cnt++;
        step();
    endtask

    task automatic test_zero();
        clear_writes();
        set_rd_all(0);
        dbg_idx = '0;
        set_wr(0, 1'b1, 0, 32'h1234);
        #1;
        total_cnt++;
        if (rd1(0) !== 32'h0 || rd2(4) !== 32'h0)
            $display("FAIL zero_same got %h/%h want 0", rd1(0), rd2(4));
        else pass_cnt++;
        step();
        clear_writes();
        #1;
        total_cnt++;
        if (rd1(0) !== 32'h0 || dbg_data !== 32'h0)
            $display("FAIL zero_next got %h/%h want 0", rd1(0), dbg_data);
        else pass_cnt++;
        total_cnt++;
        if (wr_conflict !== 1'b0) $display("FAIL zero_conflict got %b want 0", wr_conflict);
        else pass_cnt++;
        step();
    endtask

    task automatic test_conflict();
        clear_writes();
        set_rd_all(9);
        dbg_idx = 6'd9;
        set_wr(0, 1'b1, 9, 32'h1);
        set_wr(1, 1'b1, 9, 32'h2);
        #1;
        total_cnt++;
        if (rd1(0) !== 32'h2 || rd2(3) !== 32'h2)
            $display("FAIL conflict_bypass got %h/%h want 2", rd1(0), rd2(3));
        else pass_cnt++;
        step();
        clear_writes();
        #1;
        total_cnt++;
        if (rd1(1) !== 32'h2 || dbg_data !== 32'h2)
            $display("FAIL conflict_store got %h/%h want 2", rd1(1), dbg_data);
        else pass_cnt++;
        total_cnt++;
        if (wr_conflict !== 1'b1) $display("FAIL conflict_flag got %b want 1", wr_conflict);
        else pass_cnt++;
        step();
        total_cnt++;
        if (wr_conflict !== 1'b0) $display("FAIL conflict_clear got %b want 0", wr_conflict);
        else pass_cnt++;
    endtask

    task automatic test_broadcast();
        clear_writes();
        set_wr(1, 1'b1, 7, 32'hA);
        step();
        set_wr(1, 1'b0, 0, 32'h0);
        set_wr(0, 1'b1, 7, 32'hB);
        set_rd_all(7);
        #1;
        for (int k = 0; k < NUM_RD; k++) begin
            total_cnt++;
            if (rd1(k) !== 32'hB || rd2(k) !== 32'hB)
                $display("FAIL broadcast_bypass port=%0d got %h/%h want b", k, rd1(k), rd2(k));
            else pass_cnt++;
        end
        set_wr(0, 1'b0, 7, 32'hB);
        #1;
        for (int k = 0; k < NUM_RD; k++) begin
            total_cnt++;
            if (rd1(k) !== 32'hA || rd2(k) !== 32'hA)
                $display("FAIL broadcast_disabled port=%0d got %h/%h want a", k, rd1(k), rd2(k));
            else pass_cnt++;
        end
        step();
        clear_writes();
    endtask

    task automatic test_reset_mid();
        clear_writes();
        set_wr(0, 1'b1, 3, 32'h77);
        step();
        reset = 1'b1;
        set_wr(0, 1'b1, 3, 32'h55);
        set_rd_all(3);
        #1;
        total_cnt++;
        if (rd1(1) !== 32'h55) $display("FAIL reset_cycle_bypass got %h want 55", rd1(1));
        else pass_cnt++;
        step();
        reset = 1'b0;
        clear_writes();
        dbg_idx = 6'd3;
        #1;
        total_cnt++;
        if (rd1(1) !== 32'h0 || dbg_data !== 32'h0)
            $display("FAIL reset_mid got %h/%h want 0", rd1(1), dbg_data);
        else pass_cnt++;
        total_cnt++;
        if (rd1(4) !== 32'h0) $display("FAIL reset_mid_other got %h want 0 (idx 3)", rd1(4));
        else pass_cnt++;
        set_rd_all(5);
        #1;
        total_cnt++;
        if (rd2(0) !== 32'h0) $display("FAIL reset_mid_idx5 got %h want 0", rd2(0));
        else pass_cnt++;
        step();
    endtask

    function automatic logic [DATA_W-1:0] exp_read(input int idx);
        logic [DATA_W-1:0] v;
        if (idx == 0) return '0;
        v = model[idx];
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && int'(wr_idx[w*IDX_W +: IDX_W]) == idx) v = wr_data[w*DATA_W +: DATA_W];
        end
        return v;
    endfunction

    task automatic test_random();
        logic exp_conf;
        logic next_conf;
        int   idx;
        for (int i = 0; i < PHYS_REGS; i++) model[i] = '0;
        exp_conf = 1'b0;
        clear_writes();
        for (int c = 0; c < 10000; c++) begin
            // Narrow index range some cycles so bypass and conflicts happen often.
            for (int w = 0; w < NUM_WR; w++) begin
                idx = (c % 3 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
                set_wr(w, 1'($urandom_range(0, 1)), idx, $urandom);
            end
            for (int k = 0; k < NUM_RD; k++) begin
                rd_idx_1[k*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, 63));
                rd_idx_2[k*IDX_W +: IDX_W] = IDX_W'((c % 2 == 0) ? $urandom_range(0, 7)
                                                                  : $urandom_range(0, 63));
            end
            dbg_idx = IDX_W'($urandom_range(0, 63));
            #1;
            for (int k = 0; k < NUM_RD; k++) begin
                total_cnt++;
                if (rd1(k) !== exp_read(int'(rd_idx_1[k*IDX_W +: IDX_W])))
                    $display("FAIL rand_rd1 cyc=%0d port=%0d got %h want %h", c, k, rd1(k),
                             exp_read(int'(rd_idx_1[k*IDX_W +: IDX_W])));
                else pass_cnt++;
                total_cnt++;
                if (rd2(k) !== exp_read(int'(rd_idx_2[k*IDX_W +: IDX_W])))
                    $display("FAIL rand_rd2 cyc=%0d port=%0d got %h want %h", c, k, rd2(k),
                             exp_read(int'(rd_idx_2[k*IDX_W +: IDX_W])));
                else pass_cnt++;
            end
            total_cnt++;
            if (dbg_data !== (dbg_idx == 0 ? 32'h0 : model[dbg_idx]))
                $display("FAIL rand_dbg cyc=%0d got %h want %h", c, dbg_data,
                         (dbg_idx == 0 ? 32'h0 : model[dbg_idx]));
            else pass_cnt++;
            total_cnt++;
            if (wr_conflict !== exp_conf)
                $display("FAIL rand_conflict cyc=%0d got %b want %b", c, wr_conflict, exp_conf);
            else pass_cnt++;
            next_conf = 1'b0;
            if (wr_en[0] && wr_en[1] && wr_idx[0 +: IDX_W] == wr_idx[IDX_W +: IDX_W]
                && wr_idx[0 +: IDX_W] != 0) next_conf = 1'b1;
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && wr_idx[w*IDX_W +: IDX_W] != 0)
                    model[wr_idx[w*IDX_W +: IDX_W]] = wr_data[w*DATA_W +: DATA_W];
            end
            exp_conf = next_conf;
            step();
        end
        clear_writes();
    endtask

    initial begin
        reset    = 1'b1;
        rd_idx_1 = '0;
        rd_idx_2 = '0;
        dbg_idx  = '0;
        clear_writes();
        #1;
        test_reset();
        test_bypass();
        test_zero();
        test_conflict();
        test_broadcast();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
